// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REG_B   = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // Moore control word; ready_gate marks ir_write/pc_write as qualified by mem_ready
    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       ready_gate;
        logic       branch;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
    } ctrl_word_t;

    // True for the opcodes this controller can sequence
    function automatic logic is_legal_op(input logic [5:0] op);
        logic legal;
        legal = 1'b0;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: legal = 1'b1;
            default:                                      legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/multicycle_out_dec.sv
// Combinational state -> control-word decoder.
module multicycle_out_dec
    import mips_ctrl_pkg::*;
(
    input  state_t     state,
    output ctrl_word_t cw
);

    // Per-state Moore controls; anything not set stays 0
    always_comb begin
        cw = '0;
        case (state)
            S_FETCH: begin
                cw.mem_req    = 1'b1;
                cw.ir_write   = 1'b1;
                cw.pc_write   = 1'b1;
                cw.ready_gate = 1'b1;
                cw.alu_src_b  = SRCB_FOUR;
                cw.alu_op     = ALU_OP_ADD;
                cw.pc_src     = PC_SRC_ALU;
            end
            S_DECODE: begin
                cw.alu_src_b = SRCB_IMM_SH2;
                cw.alu_op    = ALU_OP_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = SRCB_IMM;
                cw.alu_op    = ALU_OP_ADD;
            end
            S_MEMRD: begin
                cw.mem_req = 1'b1;
                cw.iord    = 1'b1;
            end
            S_MEMWB: begin
                cw.reg_write  = 1'b1;
                cw.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                cw.mem_req   = 1'b1;
                cw.mem_write = 1'b1;
                cw.iord      = 1'b1;
            end
            S_RTYPEEX: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = SRCB_REG_B;
                cw.alu_op    = ALU_OP_FUNCT;
            end
            S_RTYPEWB: begin
                cw.reg_write = 1'b1;
                cw.reg_dst   = 1'b1;
            end
            S_BEQEX: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = SRCB_REG_B;
                cw.alu_op    = ALU_OP_SUB;
                cw.pc_src    = PC_SRC_ALUOUT;
                cw.branch    = 1'b1;
            end
            S_ADDIWB: begin
                cw.reg_write = 1'b1;
            end
            S_JEX: begin
                cw.pc_src   = PC_SRC_JUMP;
                cw.pc_write = 1'b1;
            end
            default: cw = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control unit: state sequencing, memory handshake and retire counter.
module multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_write,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_en,
    output logic [1:0]       pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state_dbg
);

    state_t     state;
    ctrl_word_t cw;

    multicycle_out_dec u_out_dec (
        .state (state),
        .cw    (cw)
    );

    // State sequencing; retired counts every entry into FETCH except an illegal-opcode abort
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_FETCH;
            retired <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (mem_ready) state <= S_DECODE;
                end
                S_DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW: state <= S_MEMADR;
                        OP_RTYPE:     state <= S_RTYPEEX;
                        OP_BEQ:       state <= S_BEQEX;
                        OP_ADDI:      state <= S_ADDIEX;
                        OP_J:         state <= S_JEX;
                        default:      state <= S_FETCH;
                    endcase
                end
                S_MEMADR:  state <= (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD: begin
                    if (mem_ready) state <= S_MEMWB;
                end
                S_MEMWR: begin
                    if (mem_ready) begin
                        state   <= S_FETCH;
                        retired <= retired + CNT_W'(1);
                    end
                end
                S_RTYPEEX: state <= S_RTYPEWB;
                S_ADDIEX:  state <= S_ADDIWB;
                default: begin
                    state   <= S_FETCH;
                    retired <= retired + CNT_W'(1);
                end
            endcase
        end
    end

    // Enables are forced low for the whole reset so a pending request or writeback is dropped at once
    assign mem_req    = rst_n & cw.mem_req;
    assign mem_write  = rst_n & cw.mem_write;
    assign ir_write   = rst_n & cw.ir_write & mem_ready;
    assign pc_en      = rst_n & ((cw.pc_write & (mem_ready | ~cw.ready_gate)) | (cw.branch & zero));
    assign reg_write  = rst_n & cw.reg_write;
    assign illegal_op = rst_n & (state == S_DECODE) & ~is_legal_op(opcode);

    assign iord       = cw.iord;
    assign pc_src     = cw.pc_src;
    assign alu_src_a  = cw.alu_src_a;
    assign alu_src_b  = cw.alu_src_b;
    assign alu_op     = cw.alu_op;
    assign reg_dst    = cw.reg_dst;
    assign mem_to_reg = cw.mem_to_reg;
    assign state_dbg  = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: vector table, corner sequences and random instruction stream.
module tb_multicycle_ctrl;

    localparam int unsigned CNT_W = 4;

    localparam logic [5:0] T_RTYPE = 6'b000000;
    localparam logic [5:0] T_LW    = 6'b100011;
    localparam logic [5:0] T_SW    = 6'b101011;
    localparam logic [5:0] T_BEQ   = 6'b000100;
    localparam logic [5:0] T_ADDI  = 6'b001000;
    localparam logic [5:0] T_J     = 6'b000010;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [5:0]       opcode;
    logic             zero;
    logic             mem_ready;
    logic             mem_req, mem_write, iord, ir_write, pc_en;
    logic [1:0]       pc_src, alu_src_b, alu_op;
    logic             alu_src_a, reg_write, reg_dst, mem_to_reg, illegal_op;
    logic [CNT_W-1:0] retired;
    logic [3:0]       state_dbg;
    logic [15:0]      act_ctrl;

    int n_checks = 0;
    int n_fail   = 0;
    int ret_model = 0;
    int exp_st[$];
    bit exp_mr[$];

    typedef struct {
        logic [5:0] op;
        logic       z;
        int         fw;
        int         mw;
        int         cyc;
    } vec_t;

    vec_t vecs[10];

    always #5 clk = ~clk;

    multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_write  (mem_write),
        .iord       (iord),
        .ir_write   (ir_write),
        .pc_en      (pc_en),
        .pc_src     (pc_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .illegal_op (illegal_op),
        .retired    (retired),
        .state_dbg  (state_dbg)
    );

    assign act_ctrl = {mem_req, mem_write, iord, ir_write, pc_en, pc_src, alu_src_a,
                       alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, illegal_op};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit legal(input logic [5:0] op);
        return (op == T_RTYPE) || (op == T_LW) || (op == T_SW) ||
               (op == T_BEQ) || (op == T_ADDI) || (op == T_J);
    endfunction

    // Cycle count of one instruction from the latency rules plus memory wait cycles
    function automatic int latency(input logic [5:0] op, input int fw, input int mw);
        if (!legal(op))  return fw + 2;
        if (op == T_LW)  return 5 + fw + mw;
        if (op == T_SW)  return 4 + fw + mw;
        if (op == T_RTYPE || op == T_ADDI) return 4 + fw;
        return 3 + fw;
    endfunction

    // Expected control outputs for a state, straight from the per-state control table
    function automatic logic [15:0] exp_ctrl(input int st, input bit mr, input logic z, input logic [5:0] op);
        logic mreq, mwr, io, irw, pce, asa, rw, rd, m2r, ill;
        logic [1:0] psrc, asb, aop;
        {mreq, mwr, io, irw, pce, asa, rw, rd, m2r, ill} = '0;
        psrc = 2'b00; asb = 2'b00; aop = 2'b00;
        case (st)
            0:  begin mreq = 1'b1; asb = 2'b01; irw = mr; pce = mr; end
            1:  begin asb = 2'b11; ill = !legal(op); end
            2:  begin asa = 1'b1; asb = 2'b10; end
            3:  begin mreq = 1'b1; io = 1'b1; end
            4:  begin rw = 1'b1; m2r = 1'b1; end
            5:  begin mreq = 1'b1; mwr = 1'b1; io = 1'b1; end
            6:  begin asa = 1'b1; aop = 2'b10; end
            7:  begin rw = 1'b1; rd = 1'b1; end
            8:  begin asa = 1'b1; aop = 2'b01; psrc = 2'b01; pce = z; end
            9:  begin asa = 1'b1; asb = 2'b10; end
            10: begin rw = 1'b1; end
            11: begin psrc = 2'b10; pce = 1'b1; end
            default: ;
        endcase
        return {mreq, mwr, io, irw, pce, psrc, asa, asb, aop, rw, rd, m2r, ill};
    endfunction

    function automatic void add(input int s, input bit r);
        exp_st.push_back(s);
        exp_mr.push_back(r);
    endfunction

    // Expected state walk of one instruction with its mem_ready pattern
    function automatic void build(input logic [5:0] op, input int fw, input int mw);
        exp_st.delete();
        exp_mr.delete();
        for (int i = 0; i <= fw; i++) add(0, i == fw);
        add(1, 1'($urandom));
        if (legal(op)) begin
            case (op)
                T_LW: begin
                    add(2, 1'($urandom));
                    for (int i = 0; i <= mw; i++) add(3, i == mw);
                    add(4, 1'($urandom));
                end
                T_SW: begin
                    add(2, 1'($urandom));
                    for (int i = 0; i <= mw; i++) add(5, i == mw);
                end
                T_RTYPE: begin add(6, 1'($urandom)); add(7, 1'($urandom)); end
                T_BEQ:   add(8, 1'($urandom));
                T_ADDI:  begin add(9, 1'($urandom)); add(10, 1'($urandom)); end
                default: add(11, 1'($urandom));
            endcase
        end
    endfunction

    // Drive one cycle's inputs at posedge+1, check at posedge+3, return at next posedge+1
    task automatic one_cycle(input logic [5:0] op, input logic z, input int st, input bit mr);
        opcode    = op;
        mem_ready = mr;
        zero      = (st == 8) ? z : 1'($urandom);
        #2;
        chk($sformatf("state op=%02h", op), 32'(state_dbg), 32'(st));
        chk($sformatf("ctrl op=%02h st=%0d", op, st), 32'(act_ctrl), 32'(exp_ctrl(st, mr, zero, op)));
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [5:0] op, input logic z, input int fw, input int mw, input int ncyc);
        int st;
        bit mr;
        build(op, fw, mw);
        for (int i = 0; i < ncyc; i++) begin
            st = (i < exp_st.size()) ? exp_st[i] : 0;
            mr = (i < exp_mr.size()) ? exp_mr[i] : 1'b1;
            one_cycle(op, z, st, mr);
        end
        if (legal(op)) ret_model = (ret_model + 1) % (1 << CNT_W);
        chk($sformatf("end state op=%02h", op), 32'(state_dbg), 32'd0);
        chk($sformatf("retired op=%02h", op), 32'(retired), 32'(ret_model));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " enables"}, 32'({mem_req, mem_write, ir_write, pc_en, reg_write, illegal_op}), 32'd0);
        chk({tag, " state"}, 32'(state_dbg), 32'd0);
        chk({tag, " retired"}, 32'(retired), 32'd0);
    endtask

    initial begin
        logic [5:0] op;
        int         fw, mw;
        logic [5:0] ops[6];

        // {opcode, zero, fetch waits, mem waits, expected cycles}
        vecs[0] = '{T_LW,    1'b0, 0, 0, 5};
        vecs[1] = '{T_SW,    1'b0, 0, 3, 7};
        vecs[2] = '{T_RTYPE, 1'b0, 0, 0, 4};
        vecs[3] = '{T_BEQ,   1'b1, 0, 0, 3};
        vecs[4] = '{T_BEQ,   1'b0, 0, 0, 3};
        vecs[5] = '{T_ADDI,  1'b0, 2, 0, 6};
        vecs[6] = '{T_J,     1'b0, 0, 0, 3};
        vecs[7] = '{6'h3F,   1'b0, 0, 0, 2};
        vecs[8] = '{T_LW,    1'b1, 1, 2, 8};
        vecs[9] = '{T_SW,    1'b0, 1, 0, 5};
        ops = '{T_RTYPE, T_LW, T_SW, T_BEQ, T_ADDI, T_J};

        rst_n = 1'b0;
        mem_ready = 1'b1;
        opcode = 6'd0;
        zero = 1'b0;
        #3;
        chk_reset("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int v = 0; v < 10; v++)
            run_instr(vecs[v].op, vecs[v].z, vecs[v].fw, vecs[v].mw, vecs[v].cyc);

        // Abort a load while it waits in MEMRD
        build(T_LW, 0, 3);
        for (int i = 0; i < 3; i++) one_cycle(T_LW, 1'b0, exp_st[i], exp_mr[i]);
        opcode = T_LW;
        mem_ready = 1'b0;
        #2;
        chk("memrd req before abort", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset("abort");
        ret_model = 0;
        @(posedge clk);
        #1;
        chk_reset("abort held");
        rst_n = 1'b1;

        // Sixteen R-types since reset wrap the 4-bit counter back to 0
        for (int i = 0; i < 16; i++) run_instr(T_RTYPE, 1'b0, 0, 0, 4);
        chk("retired wrap", 32'(retired), 32'd0);

        // Random instruction stream with random memory waits
        for (int i = 0; i < 40; i++) begin
            int k;
            k  = int'($urandom_range(0, 7));
            op = (k < 6) ? ops[k] : 6'($urandom);
            fw = int'($urandom_range(0, 2));
            mw = int'($urandom_range(0, 2));
            run_instr(op, 1'($urandom), fw, mw, latency(op, fw, mw));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
